// File: rtl/atanh_input_conditioner_pkg.sv
// Shared types and the clamp rule for the atanh input conditioner.
// Samples are signed Q2.8; the clamp keeps them strictly inside (-1, 1).
package atanh_pkg;

   localparam int ATANH_IN_WIDTH  = 10;
   localparam int ATANH_FRAC_BITS = 8;

   typedef logic signed [ATANH_IN_WIDTH-1:0] fxp_in_t;

   typedef struct packed {
      fxp_in_t data;
      logic    sat;
   } cond_beat_t;

   // Largest magnitude strictly below unity: 2**FRAC_BITS - 1
   localparam fxp_in_t ATANH_POS_LIM = fxp_in_t'((1 << ATANH_FRAC_BITS) - 1);
   localparam fxp_in_t ATANH_NEG_LIM = -ATANH_POS_LIM;

   function automatic cond_beat_t clamp_unit(input fxp_in_t x);
      cond_beat_t b;
      b.data = x;
      b.sat  = 1'b0;
      if (x > ATANH_POS_LIM) begin
         b.data = ATANH_POS_LIM;
         b.sat  = 1'b1;
      end else if (x < ATANH_NEG_LIM) begin
         b.data = ATANH_NEG_LIM;
         b.sat  = 1'b1;
      end
      return b;
   endfunction

endpackage

// File: rtl/atanh_input_conditioner_if.sv
// Upstream sample stream plus downstream conditioned stream with sat sideband.
interface atanh_input_conditioner_if #(
   parameter int IN_WIDTH = 10
);
   logic                       s_valid;
   logic                       s_ready;
   logic signed [IN_WIDTH-1:0] s_data;
   logic                       m_valid;
   logic                       m_ready;
   logic signed [IN_WIDTH-1:0] m_data;
   logic                       m_sat;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_sat
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_sat
   );
endinterface

// File: rtl/atanh_input_conditioner_fifo2.sv
// Two-entry order-preserving ready/valid buffer with a registered in_ready,
// so out_ready never reaches in_ready combinationally.
module atanh_fifo2
   import atanh_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  cond_beat_t in_beat,
   output logic       out_valid,
   input  logic       out_ready,
   output cond_beat_t out_beat
);

   cond_beat_t mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] occ;
   logic [1:0] occ_next;
   logic       push;
   logic       pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      occ_next = occ + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ      <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         in_ready <= 1'b0;
         mem[0]   <= '0;
         mem[1]   <= '0;
      end else begin
         occ      <= occ_next;
         in_ready <= (occ_next < 2'd2);
         if (push) begin
            mem[wr_ptr] <= in_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   assign out_valid = (occ != 2'd0);
   assign out_beat  = mem[rd_ptr];

endmodule

// File: rtl/atanh_input_conditioner.sv
// Clamps Q2.8 samples into (-1, 1), tags clamped beats, counts saturation
// events at acceptance, and buffers the result through a registered FIFO.
module atanh_input_conditioner
   import atanh_pkg::*;
#(
   parameter int IN_WIDTH  = 10,
   parameter int FRAC_BITS = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   atanh_input_conditioner_if.slave      bus,
   input  logic                          clr_count,
   output logic [CNT_WIDTH-1:0]          sat_count
);

   if (IN_WIDTH != ATANH_IN_WIDTH || FRAC_BITS != ATANH_FRAC_BITS) begin : g_cfg_err
      $error("atanh_input_conditioner: IN_WIDTH/FRAC_BITS must match atanh_pkg");
   end

   cond_beat_t in_beat;
   cond_beat_t out_beat;
   logic       in_ready;
   logic       out_valid;
   logic       accept;

   assign in_beat = clamp_unit(bus.s_data);
   assign accept  = bus.s_valid && in_ready;

   atanh_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.s_valid),
      .in_ready  (in_ready),
      .in_beat   (in_beat),
      .out_valid (out_valid),
      .out_ready (bus.m_ready),
      .out_beat  (out_beat)
   );

   assign bus.s_ready = in_ready;
   assign bus.m_valid = out_valid;
   assign bus.m_data  = out_beat.data;
   assign bus.m_sat   = out_beat.sat;

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count <= '0;
      end else if (clr_count) begin
         sat_count <= '0;
      end else if (accept && in_beat.sat && (sat_count != '1)) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule
